uart_cmd_regfile: RTL
=====================

Name: uart_cmd_regfile

Overview:
- Successor to the single-byte UART state decoder in the photo-frame control path.
- Parses framed multi-byte commands from the UART receiver (byte + done strobe) and writes a parametrised bank of state registers.
- Checks each frame with an XOR checksum, an address-range check and an inter-byte timeout, and reports faults.
- Sits between the UART RX core and the display/mode control logic; register 0 is the frame's display-mode state.

Parameters:
- NUM_REGS, 4, number of state registers (2..16).
- REG_W, 8, register width in bits; must be a multiple of 8 (8..32).
- HDR, 8'h5A, frame header byte.
- TIMEOUT_CYC, 50000, clock cycles allowed between bytes inside a frame; 0 disables the timeout.
- RESET_VAL, 0, reset value of every register.

Ports:
- i_clk_sys  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_data  in  8  received byte, valid when i_rx_done is high.
- i_rx_done  in  1  one-cycle strobe per received byte.
- o_regs  out  NUM_REGS*REG_W  register bank, flattened; reg k occupies bits [k*REG_W +: REG_W].
- o_update  out  1  one-cycle pulse when a register is written.
- o_update_addr  out  clog2(NUM_REGS)  index of the register written; held until the next update.
- o_err  out  1  one-cycle pulse on a frame error.
- o_err_code  out  2  01 checksum, 10 bad address, 11 timeout; held until the next error.
- o_busy  out  1  high while the parser is not in IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - every o_regs entry = RESET_VAL;
  - o_update = 0, o_update_addr = 0;
  - o_err = 0, o_err_code = 0;
  - o_busy = 0;
  - FSM = IDLE, timeout counter = 0.
- Frame format: HDR, ADDR, then NB = REG_W/8 data bytes MSB first, then CHK. CHK = ADDR ^ D0 ^ ... ^ D(NB-1).
- FSM states and transitions, evaluated only on i_rx_done:
  - IDLE: byte == HDR -> ADDR. Any other byte is ignored silently, with no error.
  - ADDR: latch the address, clear the running XOR to ADDR -> DATA, with byte counter = 0.
  - DATA: shift the byte into the data shift register, XOR it into the running checksum, increment the counter. When counter reaches NB-1 -> CHK.
  - CHK: compare and commit (rules below) -> IDLE.
- In ADDR, DATA and CHK, a byte equal to HDR is ordinary payload. There is no mid-frame resync.
- Commit on the CHK byte, in priority order:
  - checksum mismatch -> o_err, code 01;
  - else ADDR >= NUM_REGS -> o_err, code 10;
  - else write the register and pulse o_update with o_update_addr = ADDR.
- Commit latency: the register value, o_update and o_err are all registered. They become visible on the clock edge that samples the CHK strobe, i.e. in the cycle after i_rx_done.
- A failed frame leaves every register unchanged.
- Timeout:
  - Outside IDLE, the counter increments every cycle without i_rx_done and clears on i_rx_done.
  - When the counter reaches TIMEOUT_CYC: FSM -> IDLE, o_err pulses with code 11, counter clears.
  - If i_rx_done arrives in the same cycle the counter would expire, the byte wins: it is processed and no timeout fires.
  - In IDLE the counter is held at 0.
- Back-to-back strobes on consecutive cycles are supported. The byte after a CHK may be the next HDR and is accepted.
- o_update and o_err are never high in the same cycle.
- Reset asserted mid-frame forces every register and output to its reset value immediately (asynchronous); the partial frame is discarded.

Decomposition:
- Package uart_cmd_pkg holds:
  - FSM state encoding: IDLE, ADDR, DATA, CHK;
  - error code constants: ERR_CHK, ERR_ADDR, ERR_TMO;
  - a clog2-based helper for the address width.
- One sub-module, rx_timeout_cnt: parameter TIMEOUT_CYC; inputs clock, reset, enable (not IDLE), clear (i_rx_done); output expire pulse.

Test Plan:
All cases use NUM_REGS=4, REG_W=16, HDR=5A, TIMEOUT_CYC=20.
- Valid write: after reset, send 5A,02,12,34,24 -> o_update for 1 cycle with addr 2; reg2 = 16'h1234; reg0, reg1, reg3 = 0.
- Bad checksum: send 5A,01,AB,CD,00 -> o_err with code 01; all registers unchanged; o_busy returns to 0.
- Bad address: send 5A,07,00,01,06 -> o_err with code 10; no o_update.
- Timeout and recovery: send 5A,01, then 20 idle cycles -> o_err with code 11. Then send 5A,01,5A,5A,01 -> reg1 = 16'h5A5A.
- Noise and back-to-back: send 00,FF,5A,00,00,05,05 then immediately 5A,03,FF,00,FC, all on consecutive cycles -> reg0 = 0005, reg3 = FF00; two o_update pulses; no errors.
- Reset mid-frame: write reg2 = 1234, send 5A,02,99, then pulse i_rst -> all registers = 0; the next full frame parses normally.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser / register bank.
// Holds the parser state encoding, the error codes and the address-width helper.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_ADDR = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    // A single-register bank still needs a 1-bit index port.
    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rx_timeout_cnt.sv
// Inter-byte watchdog: counts idle cycles while a frame is open and pulses
// expire on the cycle the count would reach TIMEOUT_CYC. TIMEOUT_CYC = 0 disables it.
module rx_timeout_cnt #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [CW-1:0] cnt;

    // A byte arriving on the expiring cycle clears the count, so the byte wins.
    assign expire = (TIMEOUT_CYC != 0) && enable && !clear && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || clear || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_regfile.sv
// Framed UART command parser: HDR, ADDR, REG_W/8 data bytes MSB first, CHK.
// Valid frames write one register of the bank; bad frames report an error code.
module uart_cmd_regfile
    import uart_cmd_pkg::*;
#(
    parameter int               NUM_REGS    = 4,
    parameter int               REG_W       = 8,
    parameter logic [7:0]       HDR         = 8'h5A,
    parameter int               TIMEOUT_CYC = 50000,
    parameter logic [REG_W-1:0] RESET_VAL   = '0
) (
    input  logic                             i_clk_sys,
    input  logic                             i_rst,
    input  logic [7:0]                       i_data,
    input  logic                             i_rx_done,
    output logic [NUM_REGS*REG_W-1:0]        o_regs,
    output logic                             o_update,
    output logic [addr_width(NUM_REGS)-1:0]  o_update_addr,
    output logic                             o_err,
    output logic [1:0]                       o_err_code,
    output logic                             o_busy
);

    localparam int NB    = REG_W / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW    = addr_width(NUM_REGS);

    state_t           state;
    state_t           state_n;
    logic [7:0]       addr_q;
    logic [7:0]       chk_q;
    logic [REG_W-1:0] data_sr;
    logic [CNT_W-1:0] byte_cnt;
    logic             tmo_expire;
    logic             commit_ok;
    logic             commit_err;
    logic [1:0]       err_code_n;
    logic [REG_W-1:0] regs_q [NUM_REGS];

    rx_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (i_clk_sys),
        .rst    (i_rst),
        .enable (state != IDLE),
        .clear  (i_rx_done),
        .expire (tmo_expire)
    );

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Timeout and byte strobes are mutually exclusive by construction of expire.
    always_comb begin
        state_n    = state;
        commit_ok  = 1'b0;
        commit_err = 1'b0;
        err_code_n = o_err_code;
        if (tmo_expire) begin
            state_n    = IDLE;
            commit_err = 1'b1;
            err_code_n = ERR_TMO;
        end else if (i_rx_done) begin
            case (state)
                IDLE: if (i_data == HDR) state_n = ADDR;
                ADDR: state_n = DATA;
                DATA: if (byte_cnt == CNT_W'(NB - 1)) state_n = CHK;
                CHK: begin
                    state_n = IDLE;
                    if (chk_q != i_data) begin
                        commit_err = 1'b1;
                        err_code_n = ERR_CHK;
                    end else if (addr_q >= 8'(NUM_REGS)) begin
                        commit_err = 1'b1;
                        err_code_n = ERR_ADDR;
                    end else begin
                        commit_ok = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // The running XOR starts from ADDR so CHK covers address and payload.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            addr_q   <= '0;
            chk_q    <= '0;
            data_sr  <= '0;
            byte_cnt <= '0;
        end else if (i_rx_done) begin
            case (state)
                ADDR: begin
                    addr_q   <= i_data;
                    chk_q    <= i_data;
                    byte_cnt <= '0;
                end
                DATA: begin
                    data_sr  <= REG_W'({data_sr, i_data});
                    chk_q    <= chk_q ^ i_data;
                    byte_cnt <= byte_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else if (commit_ok) begin
            regs_q[addr_q[AW-1:0]] <= data_sr;
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            o_update      <= 1'b0;
            o_update_addr <= '0;
            o_err         <= 1'b0;
            o_err_code    <= '0;
        end else begin
            o_update   <= commit_ok;
            o_err      <= commit_err;
            o_err_code <= err_code_n;
            if (commit_ok) begin
                o_update_addr <= addr_q[AW-1:0];
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign o_regs[k*REG_W +: REG_W] = regs_q[k];
    end

    assign o_busy = (state != IDLE);

endmodule
